// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port RAM (1-cycle synchronous read).
// One transaction per grant; all outputs registered.
module mem_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic                     gnt_id,
    output logic                     busy
);

    // state    | meaning
    // ST_IDLE  | waiting for a request; arbitrate and latch command
    // ST_ISSUE | strobe presented to RAM for one cycle
    // ST_WAIT  | RAM read data valid; captured at end of cycle
    // ST_ACK   | one-cycle ack to the winning port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t state, state_next;
    logic   any_req;
    logic   win;
    logic   win_we;
    logic   last_grant;
    logic   cmd_we;

    always_comb begin
        any_req    = req0 | req1;
        win        = req1;
        state_next = state;
        if (PRIORITY_MODE == 1) begin
            win = ~req0;
        end else if (req0 && req1) begin
            win = ~last_grant;
        end
        win_we = win ? we1 : we0;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ram_addr/ram_wdata double as the latched command fields.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            gnt_id     <= 1'b0;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
        end else begin
            busy   <= (state_next != ST_IDLE);
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_id     <= win;
                        last_grant <= win;
                        cmd_we     <= win_we;
                        ram_addr   <= win ? addr1 : addr0;
                        ram_wdata  <= win ? wdata1 : wdata0;
                        ram_rd     <= ~win_we;
                        ram_wr     <= win_we;
                    end
                end
                ST_WAIT: begin
                    if (!cmd_we) begin
                        if (gnt_id) rdata1 <= ram_rdata;
                        else        rdata0 <= ram_rdata;
                    end
                    ack0 <= ~gnt_id;
                    ack1 <= gnt_id;
                end
                default: ;
            endcase
        end
    end

endmodule
